// File: rtl/exu_issue.sv
// ALU issue stage: decodes operands/op code, registers them through a 2-entry skid buffer.
// Latency 1 cycle; in_ready is registered and drops only when the skid entry is occupied.
module exu_issue #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_class,
  input  logic [2:0]      in_funct3,
  input  logic            in_f7b5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] r1,
  output logic [XLEN-1:0] r2,
  output logic [3:0]      sub,
  output logic            alu_enable,
  output logic [XLEN-1:0] out_pc,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wen,
  output logic [2:0]      out_class,
  output logic [2:0]      out_funct3
);

  localparam logic [2:0] C_OP    = 3'd0;
  localparam logic [2:0] C_OPIMM = 3'd1;
  localparam logic [2:0] C_LUI   = 3'd2;
  localparam logic [2:0] C_AUIPC = 3'd3;
  localparam logic [2:0] C_BR    = 3'd4;
  localparam logic [2:0] C_JAL   = 3'd6;
  localparam logic [2:0] C_RSV   = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [3:0]      sub;
    logic [XLEN-1:0] pc;
    logic [RD_W-1:0] rd;
    logic            wen;
    logic [2:0]      cls;
    logic [2:0]      f3;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5);
    logic [3:0] op;
    case (f3)
      3'd0:    op = f7b5 ? 4'b0001 : 4'b0000;
      3'd1:    op = 4'b1000;
      3'd2:    op = 4'b0110;
      3'd3:    op = 4'b0111;
      3'd4:    op = 4'b0101;
      3'd5:    op = f7b5 ? 4'b1010 : 4'b1001;
      3'd6:    op = 4'b0100;
      default: op = 4'b0011;
    endcase
    return op;
  endfunction

  ent_t   dec;
  ent_t   main_q;
  ent_t   skid_q;
  state_t state;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   push;
  logic   pop;

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.rd  = in_rd;
    dec.wen = in_wen;
    dec.cls = in_class;
    dec.f3  = in_funct3;

    case (in_class)
      C_AUIPC, C_JAL: dec.r1 = in_pc;
      C_LUI:          dec.r1 = '0;
      default:        dec.r1 = in_rs1;
    endcase

    case (in_class)
      C_OP, C_BR: dec.r2 = in_rs2;
      C_JAL:      dec.r2 = XLEN'(4);
      default:    dec.r2 = in_imm;
    endcase

    case (in_class)
      C_OP:    dec.sub = alu_op(in_funct3, in_f7b5);
      // OP-IMM has no SUB form: funct7 bit 30 is part of the immediate there
      C_OPIMM: dec.sub = (in_funct3 == 3'd0) ? 4'b0000 : alu_op(in_funct3, in_f7b5);
      C_BR: begin
        case (in_funct3)
          3'd0, 3'd1: dec.sub = 4'b1011;
          3'd4, 3'd5: dec.sub = 4'b0110;
          3'd6, 3'd7: dec.sub = 4'b0111;
          default:    dec.sub = 4'b0000;
        endcase
      end
      C_RSV:   dec.sub = 4'b1100;
      default: dec.sub = 4'b0000;
    endcase
  end

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_q      <= dec;
            state       <= FULL;
            out_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (push && pop) begin
            main_q <= dec;
          end else if (push) begin
            skid_q     <= dec;
            state      <= SKID;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            // clear so an idle ALU sees zero operands
            main_q      <= '0;
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        SKID: begin
          if (pop) begin
            main_q     <= skid_q;
            skid_q     <= '0;
            state      <= FULL;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          main_q      <= '0;
          skid_q      <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign alu_enable = out_valid_q;
  assign r1         = main_q.r1;
  assign r2         = main_q.r2;
  assign sub        = main_q.sub;
  assign out_pc     = main_q.pc;
  assign out_rd     = main_q.rd;
  assign out_wen    = main_q.wen;
  assign out_class  = main_q.cls;
  assign out_funct3 = main_q.f3;

endmodule
